// File: rtl/funct_generator_seq_pkg.sv
// Shared types and constants for the function-generator sequencer:
// FSM states, run modes and waveform selects.
package funct_generator_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CYCLE  = 1'b1;

    localparam logic [1:0] WAVE_0 = 2'd0;
    localparam logic [1:0] WAVE_1 = 2'd1;
    localparam logic [1:0] WAVE_2 = 2'd2;
    localparam logic [1:0] WAVE_3 = 2'd3;

    // Auto-cycle order: 0 -> 1 -> 2 -> 3 -> 0.
    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/funct_generator_seq_if.sv
// Sequencer <-> waveform mux / downstream FIFO bus.
interface funct_generator_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]                   sel_o;
    logic                         enh_o;
    logic signed [DATA_WIDTH-1:0] mux_data_i;
    logic signed [DATA_WIDTH-1:0] fifo_data_o;
    logic                         fifo_wr_o;
    logic                         fifo_full_i;

    // Handshake: fifo_wr_o is a one-cycle strobe qualifying fifo_data_o; the
    // sequencer raises it only after an edge where fifo_full_i was low, so
    // every strobe is an accepted write (fifo_full_i acts as inverted ready).
    modport master (
        output sel_o, enh_o, fifo_data_o, fifo_wr_o,
        input  mux_data_i, fifo_full_i
    );

    modport slave (
        input  sel_o, enh_o, fifo_data_o, fifo_wr_o,
        output mux_data_i, fifo_full_i
    );
endinterface

// File: rtl/funct_generator_dwell_cnt.sv
// Dwell counter: counts accepted samples and flags the terminal count so the
// sequencer can switch waveform or finish on the same edge.
module funct_generator_dwell_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] term_i,
    output logic                 wrap_o
);
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] last;

    // term_i is always >= 1, so last never underflows.
    assign last   = term_i - ONE;
    assign wrap_o = (cnt_q == last);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= wrap_o ? '0 : cnt_q + ONE;
        end
    end

endmodule

// File: rtl/funct_generator_seq.sv
// Function-generator sequencer: steers the external waveform mux and streams
// its samples into a FIFO, single-shot or auto-cycling through waveforms 0..3.
module funct_generator_seq
    import funct_generator_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 mode_i,
    input  logic [1:0]           sel_cfg_i,
    input  logic [CNT_WIDTH-1:0] dwell_i,
    funct_generator_seq_if.master bus,
    output logic                 busy_o,
    output logic                 done_o,
    output state_t               state_o
);
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                       state_q, state_d;
    logic                         mode_q, mode_d;
    logic [CNT_WIDTH-1:0]         dwell_q, dwell_d;
    logic [1:0]                   sel_q, sel_d;
    logic                         enh_q, enh_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                         wr_q, wr_d;
    logic                         done_q, done_d;
    logic                         cnt_clr, cnt_en, cnt_wrap;
    logic [CNT_WIDTH-1:0]         term;
    logic                         launch;

    // A dwell of zero still produces one sample per waveform.
    assign term   = (dwell_q == '0) ? ONE : dwell_q;
    assign launch = start_i && !stop_i;

    funct_generator_dwell_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dwell_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (term),
        .wrap_o (cnt_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= MODE_SINGLE;
            dwell_q <= '0;
            sel_q   <= WAVE_0;
            enh_q   <= 1'b0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            sel_q   <= sel_d;
            enh_q   <= enh_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        sel_d   = sel_q;
        enh_d   = enh_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d = RUN;
                    mode_d  = mode_i;
                    dwell_d = dwell_i;
                    sel_d   = (mode_i == MODE_CYCLE) ? WAVE_0 : sel_cfg_i;
                    enh_d   = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                    enh_d   = 1'b0;
                    cnt_clr = 1'b1;
                end else if (bus.fifo_full_i) begin
                    state_d = HOLD;
                end else begin
                    data_d = bus.mux_data_i;
                    wr_d   = 1'b1;
                    cnt_en = 1'b1;
                    // sel moves on the wrapping edge so the mux output is
                    // already valid for the next write.
                    if (cnt_wrap) begin
                        if (mode_q == MODE_SINGLE) begin
                            state_d = DONE;
                            enh_d   = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            sel_d = next_sel(sel_q);
                        end
                    end
                end
            end
            HOLD: begin
                if (stop_i) begin
                    state_d = IDLE;
                    enh_d   = 1'b0;
                    cnt_clr = 1'b1;
                end else if (!bus.fifo_full_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sel_o       = sel_q;
    assign bus.enh_o       = enh_q;
    assign bus.fifo_data_o = data_q;
    assign bus.fifo_wr_o   = wr_q;
    assign busy_o          = (state_q == RUN) || (state_q == HOLD);
    assign done_o          = done_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_funct_generator_seq.sv
// Bench for funct_generator_seq: behavioural waveform mux, write monitor and
// per-scenario tasks checked against a spec-level sample-order model.
module tb_funct_generator_seq;
    import funct_generator_seq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [1:0]  sel_cfg_i = 2'd0;
    logic [15:0] dwell_i = 16'd0;
    logic        busy_o, done_o;
    state_t      state_o;

    funct_generator_seq_if #(.DATA_WIDTH(32)) bus ();

    funct_generator_seq #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .mode_i    (mode_i),
        .sel_cfg_i (sel_cfg_i),
        .dwell_i   (dwell_i),
        .bus       (bus),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .state_o   (state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;

    // Waveform mux model: the sample encodes its select and the cycle number.
    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic signed [31:0] wave(input logic [1:0] s, input int unsigned c);
        logic [15:0] c16;
        c16 = 16'(c);
        return $signed({s, 14'd0, c16});
    endfunction

    assign bus.mux_data_i = bus.enh_o ? wave(bus.sel_o, cyc) : 32'sd0;

    // Spec-level expected select of the idx-th write of a sequence.
    function automatic logic [1:0] exp_sel(input bit cm, input logic [1:0] cfg,
                                           input int dw, input int idx);
        int d;
        d = (dw == 0) ? 1 : dw;
        if (cm) return 2'((idx / d) % 4);
        return cfg;
    endfunction

    // Write monitor: records each accepted write with the cycle it was captured.
    logic signed [31:0] wr_data_q[$];
    int unsigned        wr_cyc_q[$];
    int                 done_cnt = 0;
    int                 done_idx = -1;
    bit                 done_with_wr = 1'b0;
    int                 viol = 0;
    logic               mon_full;
    int unsigned        mon_cyc;

    always @(posedge clk_i) begin
        mon_full = bus.fifo_full_i;
        mon_cyc  = cyc;
        #1;
        if (bus.fifo_wr_o) begin
            wr_data_q.push_back(bus.fifo_data_o);
            wr_cyc_q.push_back(mon_cyc);
            if (mon_full) viol++;
        end
        if (done_o) begin
            done_cnt++;
            done_idx     = wr_data_q.size();
            done_with_wr = bus.fifo_wr_o;
        end
    end

    // driver tasks
    task automatic clear_mon();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt = 0;
        done_idx = -1;
        done_with_wr = 1'b0;
        viol = 0;
    endtask

    task automatic launch(input bit m, input logic [1:0] s, input logic [15:0] d);
        @(negedge clk_i);
        start_i = 1'b1; mode_i = m; sel_cfg_i = s; dwell_i = d;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        int g = 0;
        while (wr_data_q.size() < n && g < budget) begin
            @(negedge clk_i);
            g++;
        end
        ok = (wr_data_q.size() >= n);
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        int g = 0;
        while (done_cnt < n && g < budget) begin
            @(negedge clk_i);
            g++;
        end
        ok = (done_cnt >= n);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        total++; if (bus.sel_o !== 2'd0) begin bad++; $display("FAIL reset_sel: got=%0h exp=0", bus.sel_o); end
        total++; if (bus.enh_o !== 1'b0) begin bad++; $display("FAIL reset_enh: got=%0b exp=0", bus.enh_o); end
        total++; if (bus.fifo_data_o !== 32'sd0) begin bad++; $display("FAIL reset_data: got=%0h exp=0", bus.fifo_data_o); end
        total++; if (bus.fifo_wr_o !== 1'b0) begin bad++; $display("FAIL reset_wr: got=%0b exp=0", bus.fifo_wr_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%0b exp=0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got=%0b exp=0", done_o); end
        total++; if (state_o !== IDLE) begin bad++; $display("FAIL reset_state: got=%0d exp=%0d", state_o, IDLE); end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_single();
        bit ok;
        logic signed [31:0] exp;
        clear_mon();
        launch(1'b0, 2'd2, 16'd5);
        wait_writes(5, 30, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout: got=%0d writes exp=5", wr_data_q.size()); end
        repeat (2) @(negedge clk_i);
        total++; if (wr_data_q.size() != 5) begin bad++; $display("FAIL single_count: got=%0d exp=5", wr_data_q.size()); end
        for (int i = 0; i < wr_data_q.size(); i++) begin
            exp = wave(2'd2, wr_cyc_q[i]);
            total++; if (wr_data_q[i] !== exp) begin bad++; $display("FAIL single_data[%0d]: got=%0h exp=%0h", i, wr_data_q[i], exp); end
            total++; if (wr_cyc_q[i] != wr_cyc_q[0] + i) begin bad++; $display("FAIL single_consec[%0d]: got=%0d exp=%0d", i, wr_cyc_q[i], wr_cyc_q[0] + i); end
        end
        total++; if (done_cnt != 1 || done_idx != 5 || !done_with_wr) begin bad++; $display("FAIL single_done: got cnt=%0d idx=%0d wr=%0b exp 1/5/1", done_cnt, done_idx, done_with_wr); end
        total++; if (bus.enh_o !== 1'b0) begin bad++; $display("FAIL single_enh: got=%0b exp=0", bus.enh_o); end
        total++; if (state_o !== IDLE || busy_o !== 1'b0) begin bad++; $display("FAIL single_idle: got state=%0d busy=%0b exp IDLE/0", state_o, busy_o); end
    endtask

    task automatic test_random_single();
        bit ok;
        logic [1:0] s;
        int d, n;
        logic signed [31:0] exp;
        for (int it = 0; it < 6; it++) begin
            clear_mon();
            s = 2'($urandom_range(0, 3));
            d = $urandom_range(0, 6);
            n = (d == 0) ? 1 : d;
            launch(1'b0, s, 16'(d));
            ok = 1'b0;
            for (int g = 0; g < 150 && done_cnt == 0; g++) begin
                @(negedge clk_i);
                bus.fifo_full_i = ($urandom_range(0, 2) == 0);
            end
            ok = (done_cnt > 0);
            bus.fifo_full_i = 1'b0;
            repeat (2) @(negedge clk_i);
            total++; if (!ok) begin bad++; $display("FAIL rand_timeout[%0d]: got no done exp done", it); end
            total++; if (wr_data_q.size() != n) begin bad++; $display("FAIL rand_count[%0d]: got=%0d exp=%0d", it, wr_data_q.size(), n); end
            for (int i = 0; i < wr_data_q.size(); i++) begin
                exp = wave(exp_sel(1'b0, s, d, i), wr_cyc_q[i]);
                total++; if (wr_data_q[i] !== exp) begin bad++; $display("FAIL rand_data[%0d.%0d]: got=%0h exp=%0h", it, i, wr_data_q[i], exp); end
            end
            total++; if (done_cnt != 1 || done_idx != n) begin bad++; $display("FAIL rand_done[%0d]: got cnt=%0d idx=%0d exp 1/%0d", it, done_cnt, done_idx, n); end
            total++; if (viol != 0) begin bad++; $display("FAIL rand_wr_full[%0d]: got=%0d exp=0", it, viol); end
        end
    endtask

    task automatic test_cycle();
        bit ok;
        int d, n;
        logic signed [31:0] exp;
        for (int it = 0; it < 2; it++) begin
            clear_mon();
            d = (it == 0) ? 3 : $urandom_range(1, 4);
            n = (it == 0) ? 15 : 8 * d + $urandom_range(0, 3);
            launch(1'b1, 2'($urandom_range(0, 3)), 16'(d));
            wait_writes(n, 80, ok);
            stop_i = 1'b1;
            @(negedge clk_i);
            stop_i = 1'b0;
            total++; if (!ok) begin bad++; $display("FAIL cycle_timeout[%0d]: got=%0d exp=%0d", it, wr_data_q.size(), n); end
            total++; if (state_o !== IDLE || bus.enh_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL cycle_stop[%0d]: got state=%0d enh=%0b busy=%0b exp IDLE/0/0", it, state_o, bus.enh_o, busy_o); end
            repeat (3) @(negedge clk_i);
            total++; if (wr_data_q.size() != n) begin bad++; $display("FAIL cycle_count[%0d]: got=%0d exp=%0d", it, wr_data_q.size(), n); end
            for (int i = 0; i < wr_data_q.size(); i++) begin
                exp = wave(exp_sel(1'b1, 2'd0, d, i), wr_cyc_q[i]);
                total++; if (wr_data_q[i] !== exp) begin bad++; $display("FAIL cycle_data[%0d.%0d]: got=%0h exp=%0h", it, i, wr_data_q[i], exp); end
            end
            total++; if (done_cnt != 0) begin bad++; $display("FAIL cycle_done: got=%0d exp=0", done_cnt); end
        end
    endtask

    task automatic test_hold();
        bit ok;
        logic [1:0] s;
        logic signed [31:0] exp;
        clear_mon();
        s = 2'($urandom_range(0, 3));
        launch(1'b0, s, 16'd4);
        wait_writes(2, 20, ok);
        bus.fifo_full_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            total++; if (state_o !== HOLD || bus.sel_o !== s || wr_data_q.size() != 2) begin bad++; $display("FAIL hold_state[%0d]: got state=%0d sel=%0d writes=%0d exp HOLD/%0d/2", k, state_o, bus.sel_o, wr_data_q.size(), s); end
        end
        bus.fifo_full_i = 1'b0;
        wait_done(1, 20, ok);
        repeat (2) @(negedge clk_i);
        total++; if (!ok) begin bad++; $display("FAIL hold_timeout: got no done exp done"); end
        total++; if (wr_data_q.size() != 4) begin bad++; $display("FAIL hold_count: got=%0d exp=4", wr_data_q.size()); end
        for (int i = 0; i < wr_data_q.size(); i++) begin
            exp = wave(s, wr_cyc_q[i]);
            total++; if (wr_data_q[i] !== exp) begin bad++; $display("FAIL hold_data[%0d]: got=%0h exp=%0h", i, wr_data_q[i], exp); end
        end
        total++; if (viol != 0 || done_idx != 4) begin bad++; $display("FAIL hold_done: got viol=%0d idx=%0d exp 0/4", viol, done_idx); end
    endtask

    task automatic test_dwell_zero();
        bit ok;
        clear_mon();
        launch(1'b0, 2'd1, 16'd0);
        wait_done(1, 20, ok);
        repeat (3) @(negedge clk_i);
        total++; if (!ok) begin bad++; $display("FAIL dz_timeout: got no done exp done"); end
        total++; if (wr_data_q.size() != 1 || done_idx != 1 || !done_with_wr) begin bad++; $display("FAIL dz_count: got writes=%0d idx=%0d wr=%0b exp 1/1/1", wr_data_q.size(), done_idx, done_with_wr); end
    endtask

    task automatic test_start_stop_reset();
        bit ok;
        clear_mon();
        @(negedge clk_i);
        start_i = 1'b1; stop_i = 1'b1; mode_i = 1'b0; sel_cfg_i = 2'd3; dwell_i = 16'd5;
        @(negedge clk_i);
        start_i = 1'b0; stop_i = 1'b0;
        total++; if (state_o !== IDLE || busy_o !== 1'b0 || bus.enh_o !== 1'b0) begin bad++; $display("FAIL startstop: got state=%0d busy=%0b enh=%0b exp IDLE/0/0", state_o, busy_o, bus.enh_o); end
        repeat (3) @(negedge clk_i);
        total++; if (wr_data_q.size() != 0) begin bad++; $display("FAIL startstop_wr: got=%0d exp=0", wr_data_q.size()); end
        clear_mon();
        launch(1'b0, 2'd3, 16'd10);
        wait_writes(2, 20, ok);
        rst_i = 1'b1;
        @(negedge clk_i);
        total++; if (!ok) begin bad++; $display("FAIL rst_timeout: got=%0d exp=2", wr_data_q.size()); end
        total++; if (bus.sel_o !== 2'd0 || bus.enh_o !== 1'b0 || bus.fifo_data_o !== 32'sd0 || bus.fifo_wr_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || state_o !== IDLE) begin
            bad++; $display("FAIL rst_mid_run: got sel=%0d enh=%0b data=%0h wr=%0b busy=%0b done=%0b state=%0d exp all 0", bus.sel_o, bus.enh_o, bus.fifo_data_o, bus.fifo_wr_o, busy_o, done_o, state_o);
        end
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        total++; if (wr_data_q.size() != 2 || done_cnt != 0) begin bad++; $display("FAIL rst_after: got writes=%0d done=%0d exp 2/0", wr_data_q.size(), done_cnt); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        logic [1:0] s;
        logic signed [31:0] exp;
        clear_mon();
        s = 2'($urandom_range(0, 3));
        launch(1'b0, s, 16'd6);
        wait_writes(2, 20, ok);
        start_i = 1'b1; mode_i = 1'b1; sel_cfg_i = s ^ 2'd1; dwell_i = 16'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        total++; if (bus.sel_o !== s || state_o !== RUN) begin bad++; $display("FAIL ign_sel: got sel=%0d state=%0d exp %0d/RUN", bus.sel_o, state_o, s); end
        wait_done(1, 30, ok);
        repeat (2) @(negedge clk_i);
        total++; if (wr_data_q.size() != 6 || done_idx != 6) begin bad++; $display("FAIL ign_count: got writes=%0d idx=%0d exp 6/6", wr_data_q.size(), done_idx); end
        for (int i = 0; i < wr_data_q.size(); i++) begin
            exp = wave(s, wr_cyc_q[i]);
            total++; if (wr_data_q[i] !== exp) begin bad++; $display("FAIL ign_data[%0d]: got=%0h exp=%0h", i, wr_data_q[i], exp); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [1:0] s1, s2;
        logic signed [31:0] exp;
        clear_mon();
        s1 = 2'($urandom_range(0, 3));
        s2 = s1 + 2'd2;
        launch(1'b0, s1, 16'd2);
        wait_done(1, 20, ok);
        total++; if (state_o !== DONE) begin bad++; $display("FAIL b2b_done_state: got=%0d exp=%0d", state_o, DONE); end
        start_i = 1'b1; mode_i = 1'b0; sel_cfg_i = s2; dwell_i = 16'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(2, 20, ok);
        repeat (2) @(negedge clk_i);
        total++; if (wr_data_q.size() != 5 || done_cnt != 2 || done_idx != 5) begin bad++; $display("FAIL b2b_count: got writes=%0d done=%0d idx=%0d exp 5/2/5", wr_data_q.size(), done_cnt, done_idx); end
        for (int i = 0; i < wr_data_q.size(); i++) begin
            exp = wave((i < 2) ? s1 : s2, wr_cyc_q[i]);
            total++; if (wr_data_q[i] !== exp) begin bad++; $display("FAIL b2b_data[%0d]: got=%0h exp=%0h", i, wr_data_q[i], exp); end
        end
    endtask

    initial begin
        bus.fifo_full_i = 1'b0;
        test_reset();
        test_single();
        test_cycle();
        test_hold();
        test_dwell_zero();
        test_start_stop_reset();
        test_start_ignored();
        test_back_to_back();
        test_random_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/funct_generator_seq.md
FUNCT_GENERATOR_SEQ -- requirements
Module: funct_generator_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sample width, identical to the mux's data width.
REQ-002 Parameter CNT_WIDTH, default 16, dwell counter width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  one-cycle pulse; begins a sequence from IDLE or DONE.
REQ-006 stop_i  in  1  one-cycle pulse; aborts the sequence.
REQ-007 mode_i  in  1  0 = single waveform, 1 = auto-cycle through waveforms 0..3.
REQ-008 sel_cfg_i  in  2  waveform select used in single mode.
REQ-009 dwell_i  in  CNT_WIDTH  samples per waveform, unsigned.
REQ-010 fifo_full_i  in  1  downstream FIFO full; write not accepted.
REQ-011 mux_data_i  in  DATA_WIDTH signed  sample returned by the waveform mux.
REQ-012 sel_o  out  2  registered select driving the mux.
REQ-013 enh_o  out  1  registered mux enable.
REQ-014 fifo_data_o  out  DATA_WIDTH signed  registered sample to the FIFO.
REQ-015 fifo_wr_o  out  1  one-cycle write strobe qualifying fifo_data_o.
REQ-016 busy_o  out  1  high in RUN and HOLD.
REQ-017 done_o  out  1  one-cycle pulse on normal sequence completion.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, HOLD and DONE.
REQ-019 IDLE->RUN on start_i; mode_i, sel_cfg_i and dwell_i SHALL be latched on that edge; sel_o = sel_cfg_i (single) or 0 (cycle); enh_o = 1; sample count = 0.
REQ-020 A latched dwell of 0 SHALL be treated as 1.
REQ-021 In RUN with fifo_full_i = 0: fifo_data_o <= mux_data_i, fifo_wr_o <= 1, sample count +1, every cycle.
REQ-022 In RUN with fifo_full_i = 1: no write, count held, state SHALL go to HOLD.
REQ-023 HOLD->RUN when fifo_full_i = 0; sel_o and count SHALL be unchanged across HOLD.
REQ-024 The first write after a sel_o change SHALL carry the sample for the new sel_o; with the combinational mux this means 1-cycle latency, so sel_o changes on the same edge the count wraps.
REQ-025 Single mode: after dwell writes, RUN->DONE; enh_o <= 0; done_o pulses with the final write.
REQ-026 Cycle mode: after dwell writes, count SHALL clear and sel_o SHALL advance modulo 4 (3 wraps to 0); the sequence runs until stop_i.
REQ-027 stop_i in RUN or HOLD SHALL go to IDLE next edge: enh_o = 0, fifo_wr_o = 0, no done_o pulse, and any write from that same edge suppressed.
REQ-028 stop_i and start_i in the same cycle: stop_i SHALL win.
REQ-029 start_i in RUN or HOLD SHALL be ignored.
REQ-030 DONE->RUN on start_i (as REQ-019); otherwise DONE->IDLE after one cycle.
REQ-031 fifo_wr_o SHALL never assert in a cycle where fifo_full_i was high at the sampling edge.

Reset
REQ-032 rst_i SHALL be sampled only on clk_i and SHALL override all other inputs.
REQ-033 On reset: state IDLE; sel_o = 0, enh_o = 0, fifo_data_o = 0, fifo_wr_o = 0, busy_o = 0, done_o = 0; counter and latched configuration = 0.
REQ-034 Reset mid-RUN or mid-HOLD SHALL abort with no further write and no done_o pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (IDLE, RUN, HOLD, DONE), the mode constants MODE_SINGLE = 0 and MODE_CYCLE = 1, and the waveform-select constants 0..3.
REQ-036 The dwell counter SHALL be one sub-module, funct_generator_dwell_cnt, with clear, enable, terminal-count input and a wrap output.
REQ-037 The waveform mux SHALL remain a separate instance outside this block.

Verification
REQ-038 Single mode, sel_cfg = 2, dwell = 5, FIFO never full -> 5 consecutive writes equal to the waveform-2 samples, done_o with write 5, enh_o low after.
REQ-039 Cycle mode, dwell = 3 -> write pattern 3x sel 0, 3x sel 1, 3x sel 2, 3x sel 3, then 3x sel 0; stop_i -> IDLE, no done_o.
REQ-040 Single mode, dwell = 4, fifo_full_i high for 3 cycles after write 2 -> HOLD, no writes while full, exactly 4 writes total, sel_o stable.
REQ-041 dwell = 0 -> exactly 1 write, then done_o.
REQ-042 Simultaneous start_i + stop_i in IDLE -> remains IDLE; rst_i after write 2 of dwell = 10 -> all outputs 0 next cycle, no further writes.
REQ-043 start_i during RUN -> ignored, counts and sel_o unaffected.
